// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage of the five-stage RV32I pipeline. Owns the program
// counter, gathers each 32-bit instruction as four little-endian byte reads
// over a byte-wide memory port, and presents the finished word and its PC to
// the IF/ID pipeline register. While no complete instruction is presented the
// stage raises a stall request toward the pipeline controller.
//
// Parameters
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   stall[5:0]   pipeline stall vector; only stall[0] (hold this stage) is used
//   br           branch/jump taken this cycle
//   br_addr      redirect target, low two bits forced to zero
//   mem_req      byte read request (level, held until acknowledged)
//   mem_addr     byte address of the outstanding request
//   mem_ack      one-cycle acknowledge, mem_rdata valid in the same cycle
//   mem_rdata    returned byte
//   if_pc        PC of the presented instruction, 0 when nothing is presented
//   if_inst      presented instruction, 0 (bubble) when nothing is presented
//   stallreq_if  1 whenever no complete instruction is presented
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        br,
  input  logic [31:0] br_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [23:0] byte_buf;
  logic [31:0] req_addr;

  logic [1:0]  state_nxt;
  logic [31:0] pc_nxt;
  logic [1:0]  cnt_nxt;
  logic [23:0] buf_nxt;
  logic [31:0] req_addr_nxt;
  logic        req_nxt;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_inst_nxt;

  logic [31:0] br_target;
  logic [31:0] next_byte_addr;
  logic [31:0] seq_pc;

  // Only the stage-0 stall bit and the word-aligned part of the target
  // matter here; the rest is collected so it is visibly intentional.
  logic unused_bits;
  assign unused_bits = ^{stall[5:1], br_addr[1:0]};

  assign br_target      = {br_addr[31:2], 2'b00};
  assign next_byte_addr = pc + {30'd0, cnt} + 32'd1;
  assign seq_pc         = pc + 32'd4;

  // The request address lives in its own register so that a drain can keep
  // presenting the abandoned address while pc already holds the new target.
  assign mem_addr    = req_addr;
  assign stallreq_if = (state != ST_HOLD);

  // Next-state logic. A redirect overrides every normal transition; the only
  // question it leaves open is whether the memory still owes us a byte, in
  // which case we must sit in DRAIN until that byte has been returned.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    cnt_nxt      = cnt;
    buf_nxt      = byte_buf;
    req_addr_nxt = req_addr;
    req_nxt      = mem_req;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;

    if (br) begin
      pc_nxt      = br_target;
      cnt_nxt     = 2'd0;
      if_pc_nxt   = 32'd0;
      if_inst_nxt = 32'd0;
      req_nxt     = 1'b1;
      if (((state == ST_FETCH) || (state == ST_DRAIN)) && !mem_ack) begin
        state_nxt = ST_DRAIN;
      end else begin
        state_nxt    = ST_FETCH;
        req_addr_nxt = br_target;
      end
    end else begin
      case (state)
        ST_START: begin
          state_nxt    = ST_FETCH;
          req_nxt      = 1'b1;
          req_addr_nxt = pc;
        end

        ST_FETCH: begin
          if (mem_ack) begin
            if (cnt == 2'd3) begin
              if_inst_nxt = {mem_rdata, byte_buf};
              if_pc_nxt   = pc;
              state_nxt   = ST_HOLD;
              cnt_nxt     = 2'd0;
              req_nxt     = 1'b0;
            end else begin
              case (cnt)
                2'd0:    buf_nxt[7:0]   = mem_rdata;
                2'd1:    buf_nxt[15:8]  = mem_rdata;
                default: buf_nxt[23:16] = mem_rdata;
              endcase
              cnt_nxt      = cnt + 2'd1;
              req_addr_nxt = next_byte_addr;
            end
          end
        end

        ST_HOLD: begin
          if (!stall[0]) begin
            pc_nxt       = seq_pc;
            if_pc_nxt    = 32'd0;
            if_inst_nxt  = 32'd0;
            state_nxt    = ST_FETCH;
            req_nxt      = 1'b1;
            req_addr_nxt = seq_pc;
          end
        end

        default: begin
          // DRAIN: the returned byte belongs to the abandoned path and is
          // simply dropped; fetching restarts at byte 0 of the new pc.
          if (mem_ack) begin
            state_nxt    = ST_FETCH;
            cnt_nxt      = 2'd0;
            req_nxt      = 1'b1;
            req_addr_nxt = pc;
          end
        end
      endcase
    end
  end

  // State and output registers. Reset is asynchronous so a fetch in flight is
  // abandoned immediately; any late acknowledge is ignored while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_START;
      pc       <= RESET_PC;
      cnt      <= 2'd0;
      byte_buf <= 24'd0;
      req_addr <= RESET_PC;
      mem_req  <= 1'b0;
      if_pc    <= 32'd0;
      if_inst  <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      cnt      <= cnt_nxt;
      byte_buf <= buf_nxt;
      req_addr <= req_addr_nxt;
      mem_req  <= req_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//
// Bench for if_fetch. A byte memory model acknowledges requests and checks
// each acknowledged address against a queue of expected addresses; an
// instruction monitor checks every newly presented instruction against a
// queue of expected {pc, inst} pairs. Directed stimulus pushes the
// expectations and drives reset, stall and redirects. A second instance with
// RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        br;
  logic [31:0] br_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [7:0]  rdata2;
  logic [31:0] pc2;
  logic [31:0] inst2;
  logic        stallreq2;
  logic [5:0]  stall2;

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_inst[$];

  logic stray_ack  = 1'b0;
  int   wait_cnt   = 0;
  logic main_done  = 1'b0;
  logic wrap_done  = 1'b0;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br         (br),
    .br_addr    (br_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .stallreq_if(stallreq_if)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk        (clk),
    .rst        (rst2),
    .stall      (stall2),
    .br         (1'b0),
    .br_addr    (32'd0),
    .mem_req    (req2),
    .mem_addr   (addr2),
    .mem_ack    (ack2),
    .mem_rdata  (rdata2),
    .if_pc      (pc2),
    .if_inst    (inst2),
    .stallreq_if(stallreq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator shared by every checking process.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    nvec++;
    if (actual !== expected) begin
      nfail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic b, input logic [31:0] ba,
                                input logic [5:0] st);
    br      = b;
    br_addr = ba;
    stall   = st;
  endtask

  // Wait (bounded) for the main instance to present an instruction.
  task automatic wait_hold(input string name);
    int n;
    n = 0;
    while (stallreq_if && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(stallreq_if), 32'd0);
  endtask

  // Wait (bounded) for the main instance to request a given byte address.
  task automatic wait_addr(input string name, input logic [31:0] a);
    int n;
    n = 0;
    while (!(mem_req && mem_addr == a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output(name, mem_addr, a);
  endtask

  function automatic logic [7:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h4:   return 8'h93;
      32'h6:   return 8'h10;
      32'h8:   return 8'h11;
      32'h9:   return 8'h22;
      32'hA:   return 8'h33;
      32'h100: return 8'h37;
      32'h101: return 8'h05;
      32'h103: return 8'h10;
      32'h104: return 8'hAA;
      32'h105: return 8'hBB;
      32'h200: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int ack_latency(input logic [31:0] a);
    return (a == 32'hA) ? 3 : 0;
  endfunction

  // Byte memory: acknowledges a held request after its latency and checks
  // the acknowledged address against the expected request sequence.
  initial begin : mem_model
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
      end else if (!rst) begin
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_latency(mem_addr)) begin
          wait_cnt  = 0;
          mem_ack   = 1'b1;
          mem_rdata = mem_read(mem_addr);
          if (exp_addr.size() == 0) begin
            check_output("unexpected_req_addr", mem_addr, 32'hXXXX_XXXX);
          end else begin
            check_output("req_addr", mem_addr, exp_addr.pop_front());
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Instruction monitor: compares each newly presented instruction.
  initial begin : inst_monitor
    logic prev;
    logic [63:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b1;
      end else begin
        if (!stallreq_if && prev) begin
          if (exp_inst.size() == 0) begin
            check_output("unexpected_inst", if_inst, 32'hXXXX_XXXX);
          end else begin
            e = exp_inst.pop_front();
            check_output("if_pc", if_pc, e[63:32]);
            check_output("if_inst", if_inst, e[31:0]);
          end
        end
        prev = stallreq_if;
      end
    end
  end

  // Wrap-around instance: memory byte = address[7:0] ^ 0x5A, always ready.
  initial begin : wrap_mem
    ack2   = 1'b0;
    rdata2 = 8'h00;
    forever begin
      @(negedge clk);
      ack2   = rst2 && req2;
      rdata2 = addr2[7:0] ^ 8'h5A;
    end
  end

  initial begin : wrap_stim
    int n;
    rst2   = 1'b0;
    stall2 = 6'd0;
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    n = 0;
    @(negedge clk);
    while (stallreq2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("wrap_first_pc", pc2, 32'hFFFF_FFFC);
    check_output("wrap_first_inst", inst2, 32'hA5A4_A7A6);
    @(negedge clk);
    check_output("wrap_next_addr", addr2, 32'h0000_0000);
    check_output("wrap_next_req", 32'(req2), 32'd1);
    n = 0;
    while (stallreq2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    stall2 = 6'b000001;
    check_output("wrap_second_pc", pc2, 32'h0000_0000);
    check_output("wrap_second_inst", inst2, 32'h5958_5B5A);
    wrap_done = 1'b1;
  end

  // Main directed sequence.
  initial begin : stim
    int n;
    rst = 1'b0;
    apply_stimulus(1'b0, 32'd0, 6'd0);
    repeat (3) @(negedge clk);

    check_output("reset_mem_req", 32'(mem_req), 32'd0);
    check_output("reset_mem_addr", mem_addr, 32'd0);
    check_output("reset_if_pc", if_pc, 32'd0);
    check_output("reset_if_inst", if_inst, 32'd0);
    check_output("reset_stallreq", 32'(stallreq_if), 32'd1);

    for (int a = 0; a < 8; a++) exp_addr.push_back(32'(a));
    exp_inst.push_back({32'h0, 32'h0000_0013});
    exp_inst.push_back({32'h4, 32'h0010_0093});

    // First fetch: request at edge 1, HOLD at edge 5, one-cycle HOLD.
    rst = 1'b1;
    @(negedge clk);
    check_output("first_req_edge1", 32'(mem_req), 32'd1);
    check_output("first_req_addr", mem_addr, 32'd0);
    n = 1;
    while (stallreq_if && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("hold_at_edge5", 32'(n), 32'd5);
    @(negedge clk);
    check_output("hold_one_cycle", 32'(stallreq_if), 32'd1);
    check_output("next_fetch_addr", mem_addr, 32'h4);

    // Stall held for three cycles while 0x4 is presented.
    wait_hold("hold_0x4");
    apply_stimulus(1'b0, 32'd0, 6'b000001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("stall_if_pc", if_pc, 32'h4);
      check_output("stall_if_inst", if_inst, 32'h0010_0093);
      check_output("stall_mem_req", 32'(mem_req), 32'd0);
    end
    apply_stimulus(1'b0, 32'd0, 6'd0);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'h9);
    exp_addr.push_back(32'hA);
    for (int a = 0; a < 6; a++) exp_addr.push_back(32'h100 + 32'(a));
    for (int a = 0; a < 4; a++) exp_addr.push_back(32'h200 + 32'(a));
    exp_inst.push_back({32'h100, 32'h1000_0537});
    exp_inst.push_back({32'h200, 32'h0000_006F});
    @(negedge clk);
    check_output("post_stall_addr", mem_addr, 32'h8);
    check_output("post_stall_bubble", if_inst, 32'd0);

    // Redirect while byte 2 of 0x8 is outstanding: drain 0xA first.
    wait_addr("reach_0xA", 32'hA);
    apply_stimulus(1'b1, 32'h100, 6'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 32'd0, 6'd0);
    for (int k = 0; k < 3; k++) begin
      check_output("drain_addr", mem_addr, 32'hA);
      check_output("drain_req", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    check_output("after_drain_addr", mem_addr, 32'h100);

    // Redirect coincident with the ack of 0x105, unaligned target.
    wait_addr("reach_0x105", 32'h105);
    apply_stimulus(1'b1, 32'h203, 6'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 32'd0, 6'd0);
    check_output("br_ack_realign", mem_addr, 32'h200);

    // Redirect during a stalled HOLD; upper stall bits must be ignored.
    wait_hold("hold_0x200");
    apply_stimulus(1'b0, 32'd0, 6'b000001);
    @(negedge clk);
    check_output("held_pc_0x200", if_pc, 32'h200);
    for (int a = 4; a < 10; a++) exp_addr.push_back(32'(a));
    exp_inst.push_back({32'h4, 32'h0010_0093});
    apply_stimulus(1'b1, 32'h4, 6'b000001);
    @(negedge clk);
    apply_stimulus(1'b0, 32'd0, 6'b111110);
    check_output("br_in_hold_addr", mem_addr, 32'h4);
    check_output("br_in_hold_pc", if_pc, 32'd0);

    // Reset at byte 2 of 0x8, followed by a stray ack during reset.
    wait_addr("reach_0xA_again", 32'hA);
    rst = 1'b0;
    #1;
    check_output("async_rst_req", 32'(mem_req), 32'd0);
    check_output("async_rst_addr", mem_addr, 32'd0);
    check_output("async_rst_stallreq", 32'(stallreq_if), 32'd1);
    check_output("async_rst_inst", if_inst, 32'd0);
    @(negedge clk);
    #1 stray_ack = 1'b1;
    @(negedge clk);
    #1 stray_ack = 1'b0;
    @(negedge clk);
    check_output("stray_ack_req", 32'(mem_req), 32'd0);
    check_output("stray_ack_pc", if_pc, 32'd0);
    for (int a = 0; a < 4; a++) exp_addr.push_back(32'(a));
    exp_inst.push_back({32'h0, 32'h0000_0013});
    apply_stimulus(1'b0, 32'd0, 6'd0);
    rst = 1'b1;
    @(negedge clk);
    check_output("restart_addr", mem_addr, 32'd0);
    check_output("restart_req", 32'(mem_req), 32'd1);
    wait_hold("hold_restart");
    apply_stimulus(1'b0, 32'd0, 6'b000001);
    repeat (2) @(negedge clk);
    main_done = 1'b1;
  end

  initial begin : finisher
    int n;
    n = 0;
    while (!(main_done && wrap_done) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("sequence_complete", 32'(main_done && wrap_done), 32'd1);
    check_output("addr_sb_empty", 32'(exp_addr.size()), 32'd0);
    check_output("inst_sb_empty", 32'(exp_inst.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage RV32I pipeline: owns the program counter, fetches each 32-bit instruction as four byte reads over the byte-wide memory port, and presents `if_pc`/`if_inst` to the IF/ID pipeline register. It asserts a stall request while an instruction is incomplete. It honours the stage-0 bit of the pipeline stall vector. On a branch redirect it discards any partial fetch, draining an outstanding byte read first.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `stall`  in  6: pipeline stall vector. Only `stall[0]` is used; 1 = hold the PC and the presented instruction.
- `br`  in  1: branch/jump taken this cycle.
- `br_addr`  in  32: redirect target. Bits [1:0] are ignored and treated as 00.
- `mem_req`  out  1: byte read request (level).
- `mem_addr`  out  32: byte address of the request.
- `mem_ack`  in  1: one-cycle pulse; `mem_rdata` is valid this cycle.
- `mem_rdata`  in  8: returned byte.
- `if_pc`  out  32: PC of the presented instruction. Value is 0 when no instruction is presented.
- `if_inst`  out  32: presented instruction. Value is 0 (bubble) when no instruction is presented.
- `stallreq_if`  out  1: 1 whenever no complete instruction is presented.

## Operation
- State register: `pc` (32), `cnt` (2, byte index), `buf` (24, bytes 0..2), FSM state.
- FSM states and transitions:
  - START: reset state, no request. Moves to FETCH at the next edge.
  - FETCH: `mem_req`=1, `mem_addr`=`pc`+`cnt`.
    - On `mem_ack` with `cnt`<3: store `mem_rdata` in byte `cnt` of `buf`, then `cnt`++.
    - On `mem_ack` with `cnt`=3: `if_inst`<= {`mem_rdata`, `buf`}, `if_pc`<=`pc`, move to HOLD, `cnt`<=0.
  - HOLD: `mem_req`=0 and the instruction is presented.
    - If `stall[0]`=0: `pc`<=`pc`+4, clear `if_pc`/`if_inst`, move to FETCH.
    - If `stall[0]`=1: outputs are unchanged.
  - DRAIN: `mem_req`=1 with the address unchanged. Waits for `mem_ack`, discards the byte, then moves to FETCH with `cnt`=0.
- Little-endian assembly: the byte at `pc`+0 becomes `if_inst`[7:0] and the byte at `pc`+3 becomes `if_inst`[31:24].
- `stallreq_if` = (state != HOLD), combinational from the state register.
- Redirect (`br`=1) has priority over everything except reset. In every case `pc`<=`br_addr` & ~3, `cnt`<=0, and `if_pc`/`if_inst`<=0.
  - In FETCH with no `mem_ack` this cycle: go to DRAIN, because the memory still owes a byte.
  - In FETCH with `mem_ack` this cycle: drop the byte and go to FETCH.
  - In HOLD, START or DRAIN-with-ack: go to FETCH.
  - In DRAIN without ack: stay in DRAIN with the new `pc` latched. The drain still uses the old address, held in a separate `req_addr` register.
- `br` arriving during HOLD with `stall[0]`=1 still redirects. The held instruction is wrong-path.
- PC arithmetic is modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0.
- `stall[1..5]` are ignored.

## Timing
- Reset values:
  - state START, `pc`=`RESET_PC`, `cnt`=0.
  - `mem_req`=0, `mem_addr`=`RESET_PC`.
  - `if_pc`=0, `if_inst`=0, `stallreq_if`=1.
- `mem_req`, `mem_addr`, `if_pc` and `if_inst` are registered outputs.
- Memory handshake: `mem_req` and `mem_addr` stay stable until `mem_ack` is sampled high. The next byte address is driven from the following cycle. The memory must not ack a request before it has been presented for at least one edge.
- Best-case latency with a 1-cycle ack:
  - Reset release → first `mem_req` at edge 1.
  - Four acks at edges 2–5, so HOLD is entered at edge 5.
  - Steady state: 5 cycles per instruction (4 acks plus 1 HOLD cycle).
- Reset mid-fetch: everything returns to START immediately and asynchronously. Any ack for the abandoned request is ignored while `rst`=0.

## Test plan
- Reset then memory returning 0x13,0x00,0x00,0x00 at address 0 with 1-cycle ack → `if_inst`=0x0000_0013, `if_pc`=0, HOLD at edge 5, `stallreq_if` low for exactly one cycle, next `mem_addr`=0x4.
- `stall[0]` held high for 3 cycles in HOLD → `if_pc`/`if_inst` unchanged and `mem_req`=0 for all 3 cycles. Fetch of 0x4 starts the cycle after `stall[0]` falls.
- `br`=1 with `br_addr`=0x100 while byte 2 of 0x8 is outstanding and its ack comes 3 cycles later → DRAIN holds `mem_addr`=0xA until the ack, that byte is discarded, then `mem_addr`=0x100,0x101,…
- `br` coincident with an ack, and `br_addr`=0x203 → byte dropped, next request at 0x200, `if_inst` never shows a mixed-path word.
- `RESET_PC`=0xFFFF_FFFC, fetch and release → next fetch at 0x0000_0000.
- `rst` asserted at byte 2 with a subsequent stray `mem_ack` → all outputs at reset values, fetch restarts from byte 0 at `RESET_PC`.
